// File: rtl/baby_store_pkg.sv
// rtl/baby_store_pkg.sv - shared widths, FSM state type and count clamp for the Baby main store
package baby_store_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int WORDS  = 2 ** ADDR_W;
  localparam int BPW    = DATA_W / 8;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int IDX_W  = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    DUMP
  } state_t;

  // Requests larger than the store are trimmed to one full pass.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] count);
    return (count > CNT_W'(WORDS)) ? CNT_W'(WORDS) : count;
  endfunction

endpackage

// File: rtl/baby_byte_packer.sv
// rtl/baby_byte_packer.sv - byte-lane counter and word assembly register for the host loader
module baby_byte_packer
  import baby_store_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] acc;
  logic              last;

  assign last         = (idx == IDX_W'(BPW - 1));
  assign word_valid_o = byte_valid_i && last;

  // The incoming byte is merged here so the complete word is ready on the edge that accepts it.
  always_comb begin
    word_o = acc;
    word_o[{idx, 3'b000} +: 8] = byte_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx <= '0;
      acc <= '0;
    end else if (clear_i) begin
      idx <= '0;
      acc <= '0;
    end else if (byte_valid_i) begin
      acc[{idx, 3'b000} +: 8] <= byte_i;
      idx <= last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/baby_store_ctrl.sv
// rtl/baby_store_ctrl.sv - 32x32 Baby main store with byte-serial host loader
// Optional STORE_DUMP_EN adds a byte-serial dump path sharing the loader's base/count logic.
module baby_store_ctrl
  import baby_store_pkg::*;
(
  input  logic              sys_clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_rw_en_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_hold_o,
  input  logic              host_load_start_i,
  input  logic [ADDR_W-1:0] host_base_i,
  input  logic [CNT_W-1:0]  host_count_i,
  input  logic [7:0]        host_byte_i,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic              host_abort_i,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              load_err_o,
  input  logic              host_dump_start_i,
  output logic [7:0]        dump_byte_o,
  output logic              dump_valid_o,
  input  logic              dump_ready_i
);

  state_t            state;
  logic [DATA_W-1:0] mem [WORDS];
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  remaining;
  logic              hold;
  logic              ready;
  logic              busy;
  logic              done;
  logic              err;
  logic              accept;
  logic              abort_load;
  logic              word_valid;
  logic [DATA_W-1:0] word;

  assign accept     = (state == LOAD) && ready && host_valid_i && !host_abort_i;
  assign abort_load = (state == LOAD) && host_abort_i;

  baby_byte_packer u_packer (
    .clk_i        (sys_clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (abort_load),
    .byte_valid_i (accept),
    .byte_i       (host_byte_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

`ifdef STORE_DUMP_EN
  logic             dvalid;
  logic [IDX_W-1:0] didx;
  logic             dfire;

  assign dfire        = (state == DUMP) && dvalid && dump_ready_i;
  assign dump_valid_o = dvalid;
  assign dump_byte_o  = mem[ptr][{didx, 3'b000} +: 8];
`else
  logic unused_dump;
  assign unused_dump  = host_dump_start_i ^ dump_ready_i;
  assign dump_valid_o = 1'b0;
  assign dump_byte_o  = '0;
`endif

  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      hold      <= 1'b0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef STORE_DUMP_EN
      dvalid    <= 1'b0;
      didx      <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (host_load_start_i) begin
            if (host_count_i == '0) begin
              err <= 1'b1;
            end else begin
              state     <= LOAD;
              ptr       <= host_base_i;
              remaining <= clamp_count(host_count_i);
              hold      <= 1'b1;
              ready     <= 1'b1;
              busy      <= 1'b1;
            end
          end
`ifdef STORE_DUMP_EN
          else if (host_dump_start_i) begin
            if (host_count_i == '0) begin
              err <= 1'b1;
            end else begin
              state     <= DUMP;
              ptr       <= host_base_i;
              remaining <= clamp_count(host_count_i);
              hold      <= 1'b1;
              busy      <= 1'b1;
              dvalid    <= 1'b1;
              didx      <= '0;
            end
          end
`endif
        end
        LOAD: begin
          if (host_abort_i) begin
            state <= IDLE;
            hold  <= 1'b0;
            ready <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else if (word_valid) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state <= DONE;
              ready <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
`ifdef STORE_DUMP_EN
        DUMP: begin
          if (host_abort_i) begin
            state  <= IDLE;
            hold   <= 1'b0;
            busy   <= 1'b0;
            dvalid <= 1'b0;
            didx   <= '0;
            err    <= 1'b1;
          end else if (dfire) begin
            if (didx == IDX_W'(BPW - 1)) begin
              didx      <= '0;
              ptr       <= ptr + 1'b1;
              remaining <= remaining - 1'b1;
              if (remaining == CNT_W'(1)) begin
                state  <= DONE;
                dvalid <= 1'b0;
                done   <= 1'b1;
              end
            end else begin
              didx <= didx + 1'b1;
            end
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          hold  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Loader writes only happen while the core is held, so the two write sources never collide.
  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (word_valid) begin
      mem[ptr] <= word;
    end else if (cpu_rw_en_i && !hold) begin
      mem[cpu_addr_i] <= cpu_data_i;
    end
  end

  assign cpu_data_o   = mem[cpu_addr_i];
  assign cpu_hold_o   = hold;
  assign host_ready_o = ready;
  assign load_busy_o  = busy;
  assign load_done_o  = done;
  assign load_err_o   = err;

endmodule
